// File: rtl/ccg_resp_misr.sv
// ccg_resp_misr: exhaustive stimulus / MISR response compactor wrapped around
// one CCGRCG benchmark circuit. An up-counter sweeps every input vector. On each
// capture edge the circuit response is folded into a Galois MISR.
// Optional macro CCG_MISR_GOLDEN_CMP_EN adds a golden-signature compare port
// (golden in, pass out).
module ccg_resp_misr #(
  parameter int                IN_W       = 6,
  parameter int                OUT_W      = 5,
  parameter int                SIG_W      = 16,
  parameter logic [SIG_W-1:0]  POLY       = 16'hB400,
  parameter logic [SIG_W-1:0]  SEED       = 16'hFFFF,
  parameter int                SETTLE_CYC = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic [IN_W-1:0]      x,
  input  logic [OUT_W-1:0]     f,
`ifdef CCG_MISR_GOLDEN_CMP_EN
  input  logic [SIG_W-1:0]     golden,
  output logic                 pass,
`endif
  output logic                 busy,
  output logic                 done,
  output logic [SIG_W-1:0]     signature,
  output logic [IN_W:0]        vec_cnt
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_APPLY = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYC);

  state_t             state_q, state_d;
  logic [IN_W-1:0]    x_q, x_d;
  logic [SIG_W-1:0]   sig_q, sig_d;
  logic [IN_W:0]      vec_cnt_q, vec_cnt_d;
  logic [3:0]         settle_q, settle_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               capture;
  logic               last_vec;
  logic [SIG_W-1:0]   f_ext;
  logic [SIG_W-1:0]   sig_next;
`ifdef CCG_MISR_GOLDEN_CMP_EN
  logic               pass_q, pass_d;
`endif

  // Capture qualifier and the MISR update the capture edge would load.
  always_comb begin
    capture  = (state_q == S_APPLY) && (settle_q == 4'd0);
    last_vec = (x_q == {IN_W{1'b1}});
    f_ext    = '0;
    f_ext[OUT_W-1:0] = f;
    sig_next = {1'b0, sig_q[SIG_W-1:1]} ^ (sig_q[0] ? POLY : '0) ^ f_ext;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic: start only honoured in IDLE, DONE lasts one cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_APPLY;
      S_APPLY: if (capture && last_vec) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output / datapath next values; every output is a flop so f never reaches an output combinationally.
  always_comb begin
    x_d       = x_q;
    sig_d     = sig_q;
    vec_cnt_d = vec_cnt_q;
    settle_d  = settle_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
`ifdef CCG_MISR_GOLDEN_CMP_EN
    pass_d    = pass_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          x_d       = '0;
          sig_d     = SEED;
          vec_cnt_d = '0;
          busy_d    = 1'b1;
          settle_d  = SETTLE_INIT;
`ifdef CCG_MISR_GOLDEN_CMP_EN
          pass_d    = 1'b0;
`endif
        end
      end
      S_APPLY: begin
        if (settle_q != 4'd0) begin
          settle_d = settle_q - 4'd1;
        end else begin
          sig_d     = sig_next;
          vec_cnt_d = vec_cnt_q + (IN_W+1)'(1);
          if (last_vec) begin
            busy_d = 1'b0;
            done_d = 1'b1;
`ifdef CCG_MISR_GOLDEN_CMP_EN
            pass_d = (sig_next == golden);
`endif
          end else begin
            x_d      = x_q + IN_W'(1);
            settle_d = SETTLE_INIT;
          end
        end
      end
      default: ;
    endcase
  end

  // Datapath and output registers; reset discards any partial signature.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q       <= '0;
      sig_q     <= SEED;
      vec_cnt_q <= '0;
      settle_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef CCG_MISR_GOLDEN_CMP_EN
      pass_q    <= 1'b0;
`endif
    end else begin
      x_q       <= x_d;
      sig_q     <= sig_d;
      vec_cnt_q <= vec_cnt_d;
      settle_q  <= settle_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
`ifdef CCG_MISR_GOLDEN_CMP_EN
      pass_q    <= pass_d;
`endif
    end
  end

  assign x         = x_q;
  assign signature = sig_q;
  assign vec_cnt   = vec_cnt_q;
  assign busy      = busy_q;
  assign done      = done_q;
`ifdef CCG_MISR_GOLDEN_CMP_EN
  assign pass      = pass_q;
`endif

endmodule

// File: tb/tb_ccg_resp_misr.sv
// Directed bench for ccg_resp_misr: reset, sweep timing, compaction,
// settle timing, start-while-busy, and (with CCG_MISR_GOLDEN_CMP_EN) pass.
module tb_ccg_resp_misr;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start0 = 1'b0, start1 = 1'b0, start2 = 1'b0;
  logic [5:0]  x0, x1, x2;
  logic [4:0]  f0, f1, f2;
  logic        busy0, busy1, busy2, done0, done1, done2;
  logic [15:0] sig0, sig1, sig2;
  logic [6:0]  vc0, vc1, vc2;
  logic        use_ckt = 1'b0;
  logic        flip17 = 1'b0;
  logic [15:0] golden0 = 16'h0000;
`ifdef CCG_MISR_GOLDEN_CMP_EN
  logic        pass0, pass1, pass2;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // Stand-in combinational circuit under test.
  function automatic logic [4:0] ckt(input logic [5:0] v);
    return v[4:0] ^ {v[5], 3'b000, v[5] & v[3]};
  endfunction

  assign f0 = use_ckt ? (ckt(x0) ^ ((flip17 && x0 == 6'd17) ? 5'b00100 : 5'b00000)) : 5'b00000;
  assign f1 = 5'h1F;
  assign f2 = ckt(x2);

  // Reference signature over a full 64-vector sweep.
  function automatic logic [15:0] misr_ref(input logic [15:0] seed, input logic [15:0] poly,
                                           input bit uc, input bit fl);
    logic [15:0] s;
    logic [4:0]  fv;
    s = seed;
    for (int v = 0; v < 64; v++) begin
      fv = uc ? ckt(6'(v)) : 5'b00000;
      if (fl && v == 17) fv = fv ^ 5'b00100;
      if (s[0]) s = (s >> 1) ^ poly;
      else      s = s >> 1;
      s = s ^ {11'b0, fv};
    end
    return s;
  endfunction

  ccg_resp_misr u0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .x(x0), .f(f0),
`ifdef CCG_MISR_GOLDEN_CMP_EN
    .golden(golden0), .pass(pass0),
`endif
    .busy(busy0), .done(done0), .signature(sig0), .vec_cnt(vc0));

  ccg_resp_misr #(.POLY(16'h0000), .SEED(16'h0000)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .x(x1), .f(f1),
`ifdef CCG_MISR_GOLDEN_CMP_EN
    .golden(16'h0000), .pass(pass1),
`endif
    .busy(busy1), .done(done1), .signature(sig1), .vec_cnt(vc1));

  ccg_resp_misr #(.SETTLE_CYC(2)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .x(x2), .f(f2),
`ifdef CCG_MISR_GOLDEN_CMP_EN
    .golden(16'h0000), .pass(pass2),
`endif
    .busy(busy2), .done(done2), .signature(sig2), .vec_cnt(vc2));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Full sweep on u0, optional extra start pulses in cycles ps1/ps2 and during DONE.
  task automatic sweep0(input int ps1, input int ps2, input bit start_in_done,
                        input logic [15:0] exp_sig, input bit exp_pass);
    @(negedge clk); start0 = 1'b1;
    @(posedge clk); #1 start0 = 1'b0;
    for (int k = 1; k <= 64; k++) begin
      @(negedge clk);
      chk("sweep_x", x0, 32'(k - 1));
      chk("sweep_busy", busy0, 1);
      chk("sweep_nodone", done0, 0);
`ifdef CCG_MISR_GOLDEN_CMP_EN
      if (k == 1) chk("pass_cleared", pass0, 0);
`endif
      if (k == ps1 || k == ps2) begin
        start0 = 1'b1;
        @(posedge clk); #1 start0 = 1'b0;
      end
    end
    @(negedge clk);
    chk("done_c65", done0, 1);
    chk("busy_low_at_done", busy0, 0);
    chk("vec_cnt_64", vc0, 64);
    chk("x_holds_63", x0, 63);
    chk("sig_at_done", sig0, exp_sig);
`ifdef CCG_MISR_GOLDEN_CMP_EN
    chk("pass", pass0, exp_pass);
`endif
    if (start_in_done) start0 = 1'b1;
    @(posedge clk); #1 start0 = 1'b0;
    @(negedge clk);
    chk("done_one_cycle", done0, 0);
    chk("idle_after_done", busy0, 0);
    chk("sig_held", sig0, exp_sig);
    @(negedge clk);
    chk("no_restart", busy0, 0);
  endtask

  initial begin
    bit found;
    int pulses;
    logic [15:0] ref_zero, ref_ckt, ref_flip;
    ref_zero = misr_ref(16'hFFFF, 16'hB400, 1'b0, 1'b0);
    ref_ckt  = misr_ref(16'hFFFF, 16'hB400, 1'b1, 1'b0);
    ref_flip = misr_ref(16'hFFFF, 16'hB400, 1'b1, 1'b1);

    // Reset values
    #12;
    chk("rst_x", x0, 0);
    chk("rst_busy", busy0, 0);
    chk("rst_done", done0, 0);
    chk("rst_sig", sig0, 16'hFFFF);
    chk("rst_vc", vc0, 0);
    chk("rst_sig_seed0", sig1, 16'h0000);
    @(negedge clk); rst_n = 1'b1;

    // Reset mid-sweep at x=23
    @(negedge clk); start0 = 1'b1;
    @(posedge clk); #1 start0 = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 100 && !found; k++) begin
      @(negedge clk);
      if (x0 == 6'd23) found = 1'b1;
    end
    chk("reach_x23", found, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_x", x0, 0);
    chk("mid_rst_busy", busy0, 0);
    chk("mid_rst_done", done0, 0);
    chk("mid_rst_sig", sig0, 16'hFFFF);
    chk("mid_rst_vc", vc0, 0);
    @(negedge clk); rst_n = 1'b1;
    pulses = 0;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if (done0) pulses++;
    end
    chk("no_done_after_rst", pulses, 0);
    chk("idle_after_rst", busy0, 0);

    // Plain sweep, f tied 0
    use_ckt = 1'b0;
    golden0 = ref_zero;
    sweep0(0, 0, 1'b0, ref_zero, 1'b1);

    // Circuit responses, start pulses at cycles 10 and 40 and during DONE
    use_ckt = 1'b1;
    golden0 = ref_ckt;
    sweep0(10, 40, 1'b1, ref_ckt, 1'b1);

    // f[2] flipped at x=17 only: signature differs from golden
    flip17 = 1'b1;
    sweep0(0, 0, 1'b0, ref_flip, 1'b0);
    chk("flip_changes_sig", (ref_flip != ref_ckt), 1);
    flip17 = 1'b0;

    // Compaction: POLY=0, SEED=0, f=1F -> 0x0015
    @(negedge clk); start1 = 1'b1;
    @(posedge clk); #1 start1 = 1'b0;
    found = 1'b0;
    pulses = 0;
    for (int k = 1; k <= 100 && !found; k++) begin
      @(negedge clk);
      if (done1) begin found = 1'b1; pulses = k; end
    end
    chk("cmp_done_seen", found, 1);
    chk("cmp_done_cycle", pulses, 65);
    chk("cmp_sig", sig1, 16'h0015);
    chk("cmp_vc", vc1, 64);

    // Settle: SETTLE_CYC=2 -> 3 cycles per vector, done in cycle 193
    @(negedge clk); start2 = 1'b1;
    @(posedge clk); #1 start2 = 1'b0;
    pulses = 0;
    for (int k = 1; k <= 192; k++) begin
      @(negedge clk);
      if (x2 != 6'((k - 1) / 3)) pulses++;
      if (done2) pulses++;
    end
    chk("settle_x_hold3", pulses, 0);
    @(negedge clk);
    chk("settle_done_c193", done2, 1);
    chk("settle_vc", vc2, 64);
    chk("settle_sig", sig2, ref_ckt);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
